// File: rtl/lane_merge_pkg.sv
// Shared defaults and selector encoding for the two-lane merge block.
package lane_merge_pkg;
  localparam int LM_DATA_W     = 8;
  localparam int LM_FIFO_DEPTH = 4;

  typedef enum logic {
    SEL0 = 1'b0,
    SEL1 = 1'b1
  } sel_e;
endpackage

// File: rtl/lane_merge_fifo.sv
// Per-lane FIFO: register-array storage, wrapping pointers, explicit occupancy count.
module lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         push_ok, pop_ok;

  assign count = cnt_q;
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    push_ok  = push && (!full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/lane_merge.sv
// Recombines two alternating byte lanes into one ordered stream with a registered output stage.
module lane_merge
  import lane_merge_pkg::*;
#(
  parameter int DATA_W     = LM_DATA_W,
  parameter int FIFO_DEPTH = LM_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in1,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              full0,
  output logic              full1,
  output logic              err_overflow
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  sel_e              sel_q, sel_d;
  logic [DATA_W-1:0] data_out_q, data_out_d, dout0, dout1, head;
  logic              valid_out_q, valid_out_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt0, cnt1;
  logic              empty0, empty1, pop0, pop1, pop_sel, sel_empty, eligible;

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .reset(reset), .push(valid_in0), .pop(pop0), .din(data_in0),
    .dout(dout0), .count(cnt0), .full(full0), .empty(empty0)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .reset(reset), .push(valid_in1), .pop(pop1), .din(data_in1),
    .dout(dout1), .count(cnt1), .full(full1), .empty(empty1)
  );

  // Output-side decode: the selected lane is the only one ever popped, so an empty lane stalls the stream.
  always_comb begin
    eligible  = !valid_out_q || ready_in;
    sel_empty = (sel_q == SEL0) ? empty0 : empty1;
    head      = (sel_q == SEL0) ? dout0 : dout1;
    pop_sel   = eligible && !sel_empty;
    pop0      = pop_sel && (sel_q == SEL0);
    pop1      = pop_sel && (sel_q == SEL1);
  end

  always_comb begin
    sel_d = sel_q;
    if (pop_sel) sel_d = (sel_q == SEL0) ? SEL1 : SEL0;
  end

  always_comb begin
    data_out_d  = data_out_q;
    valid_out_d = valid_out_q;
    if (eligible) valid_out_d = !sel_empty;
    if (pop_sel)  data_out_d  = head;
    err_d = err_q
          | (valid_in0 && (cnt0 == CNT_W'(FIFO_DEPTH)) && !pop0)
          | (valid_in1 && (cnt1 == CNT_W'(FIFO_DEPTH)) && !pop1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= SEL0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      err_q       <= err_d;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign err_overflow = err_q;
endmodule

// File: tb/tb_lane_merge.sv
// Directed bench for lane_merge: table of per-cycle vectors plus hand-written multi-cycle sequences.
module tb_lane_merge;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in0, data_in1, data_out;
  logic       valid_in0, valid_in1, ready_in, valid_out, full0, full1, err_overflow;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    string      name;
    bit         rst;
    bit         v0;
    logic [7:0] d0;
    bit         v1;
    logic [7:0] d1;
    bit         rdy;
    bit         evo;
    logic [7:0] edo;
    bit         ef0;
    bit         ef1;
    bit         eerr;
  } vec_t;

  vec_t tbl[18];

  lane_merge #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .data_in0(data_in0), .valid_in0(valid_in0),
    .data_in1(data_in1), .valid_in1(valid_in1),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
    .full0(full0), .full1(full1), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, bit rst, bit v0, logic [7:0] d0, bit v1, logic [7:0] d1,
                              bit rdy, bit evo, logic [7:0] edo, bit ef0, bit ef1, bit eerr);
    vec_t v;
    v.name = nm; v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.rdy = rdy;
    v.evo = evo; v.edo = edo; v.ef0 = ef0; v.ef1 = ef1; v.eerr = eerr;
    return v;
  endfunction

  task automatic cmp(string nm, string what, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s %s: got %02h expected %02h", nm, what, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check outputs just after the edge.
  task automatic run(vec_t v);
    reset = v.rst; valid_in0 = v.v0; data_in0 = v.d0;
    valid_in1 = v.v1; data_in1 = v.d1; ready_in = v.rdy;
    @(posedge clk); #1;
    cmp(v.name, "valid_out", {7'd0, valid_out}, {7'd0, v.evo});
    if (v.evo || v.rst) cmp(v.name, "data_out", data_out, v.edo);
    cmp(v.name, "full0", {7'd0, full0}, {7'd0, v.ef0});
    cmp(v.name, "full1", {7'd0, full1}, {7'd0, v.ef1});
    cmp(v.name, "err_overflow", {7'd0, err_overflow}, {7'd0, v.eerr});
  endtask

  task automatic cyc(string nm, bit rst, bit v0, logic [7:0] d0, bit v1, logic [7:0] d1, bit rdy,
                     bit evo, logic [7:0] edo, bit ef0, bit ef1, bit eerr);
    run(mk(nm, rst, v0, d0, v1, d1, rdy, evo, edo, ef0, ef1, eerr));
  endtask

  initial begin
    reset = 1'b1; valid_in0 = 1'b0; valid_in1 = 1'b0;
    data_in0 = '0; data_in1 = '0; ready_in = 1'b0;

    // Reset, alternating lanes, then lane1 running ahead of lane0.
    tbl[0]  = mk("reset",     1, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    tbl[1]  = mk("alt_w_a0",  0, 1, 8'hA0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    tbl[2]  = mk("alt_o_a0",  0, 0, 8'h00, 1, 8'hB0, 1, 1, 8'hA0, 0, 0, 0);
    tbl[3]  = mk("alt_o_b0",  0, 1, 8'hA1, 0, 8'h00, 1, 1, 8'hB0, 0, 0, 0);
    tbl[4]  = mk("alt_o_a1",  0, 0, 8'h00, 1, 8'hB1, 1, 1, 8'hA1, 0, 0, 0);
    tbl[5]  = mk("alt_o_b1",  0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hB1, 0, 0, 0);
    tbl[6]  = mk("alt_idle",  0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    tbl[7]  = mk("ahead_11",  0, 0, 8'h00, 1, 8'h11, 1, 0, 8'h00, 0, 0, 0);
    tbl[8]  = mk("ahead_22",  0, 0, 8'h00, 1, 8'h22, 1, 0, 8'h00, 0, 0, 0);
    tbl[9]  = mk("ahead_stl", 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    tbl[10] = mk("ahead_w33", 0, 1, 8'h33, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    tbl[11] = mk("ahead_o33", 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h33, 0, 0, 0);
    tbl[12] = mk("ahead_o11", 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h11, 0, 0, 0);
    tbl[13] = mk("ahead_wt",  0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    tbl[14] = mk("ahead_w44", 0, 1, 8'h44, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    tbl[15] = mk("ahead_o44", 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h44, 0, 0, 0);
    tbl[16] = mk("ahead_o22", 0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h22, 0, 0, 0);
    tbl[17] = mk("ahead_end", 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    for (int i = 0; i < 18; i++) run(tbl[i]);

    // Backpressure: 0x5A held three cycles, released on the fourth.
    cyc("bp_w5a",   0, 1, 8'h5A, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    cyc("bp_load",  0, 0, 8'h00, 1, 8'h66, 0, 1, 8'h5A, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc("bp_hold", 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h5A, 0, 0, 0);
    cyc("bp_rel",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h66, 0, 0, 0);
    cyc("bp_idle",  0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);

    // Overflow: output stalled on lane1, five lane0 writes, fifth dropped, flag sticky.
    cyc("ov_w01",   0, 1, 8'h01, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    cyc("ov_stall", 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h01, 0, 0, 0);
    cyc("ov_c0",    0, 1, 8'hC0, 0, 8'h00, 0, 1, 8'h01, 0, 0, 0);
    cyc("ov_c1",    0, 1, 8'hC1, 0, 8'h00, 0, 1, 8'h01, 0, 0, 0);
    cyc("ov_c2",    0, 1, 8'hC2, 0, 8'h00, 0, 1, 8'h01, 0, 0, 0);
    cyc("ov_c3",    0, 1, 8'hC3, 0, 8'h00, 0, 1, 8'h01, 1, 0, 0);
    cyc("ov_c4",    0, 1, 8'hC4, 0, 8'h00, 0, 1, 8'h01, 1, 0, 1);
    cyc("ov_stky",  0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h01, 1, 0, 1);
    cyc("ov_wd0",   0, 0, 8'h00, 1, 8'hD0, 0, 1, 8'h01, 1, 0, 1);
    cyc("ov_od0",   0, 0, 8'h00, 1, 8'hD1, 1, 1, 8'hD0, 1, 0, 1);
    cyc("ov_oc0",   0, 0, 8'h00, 1, 8'hD2, 1, 1, 8'hC0, 0, 0, 1);
    cyc("ov_od1",   0, 0, 8'h00, 1, 8'hD3, 1, 1, 8'hD1, 0, 0, 1);
    cyc("ov_oc1",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hC1, 0, 0, 1);
    cyc("ov_od2",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hD2, 0, 0, 1);
    cyc("ov_oc2",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hC2, 0, 0, 1);
    cyc("ov_od3",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hD3, 0, 0, 1);
    cyc("ov_oc3",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hC3, 0, 0, 1);
    cyc("ov_wd4",   0, 0, 8'h00, 1, 8'hD4, 1, 0, 8'h00, 0, 0, 1);
    cyc("ov_od4",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hD4, 0, 0, 1);
    cyc("ov_drop",  0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1);

    // Mid-stream reset with bytes buffered; inputs during reset ignored.
    cyc("mr_e0",    0, 1, 8'hE0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
    cyc("mr_e1",    0, 1, 8'hE1, 0, 8'h00, 0, 1, 8'hE0, 0, 0, 1);
    cyc("mr_f0",    0, 0, 8'h00, 1, 8'hF0, 0, 1, 8'hE0, 0, 0, 1);
    cyc("mr_e2",    0, 1, 8'hE2, 0, 8'h00, 0, 1, 8'hE0, 0, 0, 1);
    cyc("mr_rst",   1, 1, 8'h55, 1, 8'h56, 1, 0, 8'h00, 0, 0, 0);
    cyc("mr_w77",   0, 1, 8'h77, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);
    cyc("mr_o77",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h77, 0, 0, 0);
    cyc("mr_empty", 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);

    // Push into a full lane0 in the same cycle it is popped.
    cyc("fp_rst",   1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    cyc("fp_w90",   0, 1, 8'h90, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    cyc("fp_w91",   0, 1, 8'h91, 0, 8'h00, 0, 1, 8'h90, 0, 0, 0);
    cyc("fp_w92",   0, 1, 8'h92, 1, 8'hB5, 0, 1, 8'h90, 0, 0, 0);
    cyc("fp_w93",   0, 1, 8'h93, 1, 8'hB6, 0, 1, 8'h90, 0, 0, 0);
    cyc("fp_w94",   0, 1, 8'h94, 1, 8'hB7, 0, 1, 8'h90, 1, 0, 0);
    cyc("fp_wb8",   0, 0, 8'h00, 1, 8'hB8, 0, 1, 8'h90, 1, 1, 0);
    cyc("fp_ob5",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hB5, 1, 0, 0);
    cyc("fp_w99",   0, 1, 8'h99, 0, 8'h00, 1, 1, 8'h91, 1, 0, 0);
    cyc("fp_ob6",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hB6, 1, 0, 0);
    cyc("fp_o92",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h92, 0, 0, 0);
    cyc("fp_ob7",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hB7, 0, 0, 0);
    cyc("fp_o93",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h93, 0, 0, 0);
    cyc("fp_ob8",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hB8, 0, 0, 0);
    cyc("fp_o94",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h94, 0, 0, 0);
    cyc("fp_wba",   0, 0, 8'h00, 1, 8'hBA, 1, 0, 8'h00, 0, 0, 0);
    cyc("fp_oba",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'hBA, 0, 0, 0);
    cyc("fp_o99",   0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h99, 0, 0, 0);
    cyc("fp_end",   0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
